// File: rtl/alu_seq_unit.sv
// ALU execute stage: single-cycle bitwise/arithmetic ops plus an iterative
// shift-add unsigned multiply. The result and flags are registered and stay
// unchanged until the next completion. A start/busy/done handshake feeds the
// register-file write-back stage.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for start; single-cycle ops complete in this state
// S_MUL  | multiply in progress; start is ignored, busy=1
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum, diff, single_res, acc_step;
  logic             single_ovf;

  // One multiply iteration: conditionally add the shifted multiplicand.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle datapath result and signed-overflow flag.
  always_comb begin
    sum        = a + b;
    diff       = a - b;
    single_res = '0;
    single_ovf = 1'b0;
    case (op)
      OP_AND: single_res = a & b;
      OP_OR:  single_res = a | b;
      OP_XOR: single_res = a ^ b;
      OP_NOR: single_res = ~(a | b);
      OP_ADD: begin
        single_res = sum;
        single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = diff;
        single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: single_res = '0;
    endcase
  end

  // Next-state logic; cnt_q counts down the remaining multiply iterations.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            state_d  = S_MUL;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            ovf_d    = single_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_MUL);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed cases with literal expectations plus
// random traffic, all compared every cycle against a behavioural model.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero, ovf, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] ref_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return x + y;
      3'd5: return x - y;
      3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 3'd4) r = sx + sy;
    else if (o == 3'd5) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[W-1:0];
  endfunction

  int           m_rem = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_result = '0;
  logic         m_zero = 1'b0, m_ovf = 1'b0, m_done = 1'b0;

  // Model: a multiply occupies the unit for W edges, other ops complete next edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem <= 0; m_pend <= '0; m_result <= '0;
      m_zero <= 1'b0; m_ovf <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_result <= m_pend;
          m_zero   <= (m_pend == 0);
          m_ovf    <= 1'b0;
          m_done   <= 1'b1;
        end
      end else if (start) begin
        if (op == 3'd7) begin
          m_rem  <= W;
          m_pend <= ref_mul(a, b);
        end else begin
          m_result <= ref_res(op, a, b);
          m_zero   <= (ref_res(op, a, b) == 0);
          m_ovf    <= ref_ovf(op, a, b);
          m_done   <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_result", result, m_result);
      chk("cyc_zero", 32'(zero), 32'(m_zero));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_rem != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_mult(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_r, input logic exp_z);
    bit got;
    got = 1'b0;
    issue(3'd7, x, y);
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(got), 32'd1);
    chk({name, "_res"}, result, exp_r);
    chk({name, "_zero"}, 32'(zero), 32'(exp_z));
    chk({name, "_ovf"}, 32'(ovf), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] la, lb;
    logic [W-1:0] lexp [4];
    int busy_cnt, done_cnt;
    la = 32'hF0F0_00FF;
    lb = 32'h0FF0_0F0F;
    lexp[0] = 32'h00F0_000F;
    lexp[1] = 32'hFFF0_0FFF;
    lexp[2] = 32'hFF00_0FF0;
    lexp[3] = 32'h000F_F000;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      issue(3'(i), la, lb);
      chk($sformatf("logic%0d_res", i), result, lexp[i]);
      chk($sformatf("logic%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("logic%0d_busy", i), 32'(busy), 32'd0);
    end

    issue(3'd4, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_res", result, 32'h8000_0000);
    chk("add_ovf_flag", 32'(ovf), 32'd1);
    issue(3'd5, 32'd5, 32'd5);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_ovf", 32'(ovf), 32'd0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", result, 32'd1);

    // MULT 1234*5678 with an ADD start attempted mid-multiply
    issue(3'd7, 32'd1234, 32'd5678);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("mul1_res", result, 32'h006A_E9BC);
        chk("mul1_dec", result, 32'd7006652);
      end
      if (i == 5) begin op = 3'd4; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("mul1_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("mul1_done_pulses", 32'(done_cnt), 32'd1);

    run_mult("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_mult("mul_zero", 32'd0, 32'h1234, 32'd0, 1'b1);

    // Reset during a multiply
    issue(3'd7, 32'd77, 32'd99);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    issue(3'd4, 32'd2, 32'd3);
    chk("post_rst_add", result, 32'd5);

    // Back-to-back: ADD then AND on the done cycle
    op = 3'd4; a = 32'd100; b = 32'd23; start = 1'b1;
    @(negedge clk);
    chk("b2b_add_done", 32'(done), 32'd1);
    chk("b2b_add_res", result, 32'd123);
    op = 3'd0; a = 32'hFF00_FF00; b = 32'h0FF0_0FF0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_and_done", 32'(done), 32'd1);
    chk("b2b_and_res", result, 32'h0F00_0F00);
    @(negedge clk);
    chk("b2b_idle_done", 32'(done), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 1) == 1);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
        2: begin a = 32'h7FFF_FFFF - 32'($urandom_range(0, 2)); b = $urandom; end
        default: begin a = $urandom; b = a; end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
